sseg_scan_decoder: RTL and testbench
====================================

# sseg_scan_decoder

Receive-side monitor for the multiplexed 8-digit seven-segment bus. It samples the active-low anode and cathode lines driven by the display scanner and tracks the scan order. It reconstructs each digit's hex value and decimal point, then presents a complete 8-digit frame to a consumer through a valid/ack handshake. It sits on the same CLK as the display driver and is used for loopback self-test and on-board verification of the display path.

## Interface
- SETTLE_CYCLES, 4: number of consecutive identical samples (AN and CA) required before a dwell is accepted. Legal range is 2..255.
- TIMEOUT_CYCLES, 1048576: number of cycles without an accepted dwell before STALLED asserts. Legal range is ≥ 2·SETTLE_CYCLES.

- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- SSEG_AN  in  8  anode enables, active-low; bit i selects digit position i.
- SSEG_CA  in  8  cathodes, active-low: bit 7 = dp, bits 6..0 = segments g..a.
- FRAME_ACK  in  1  consumer acknowledge for FRAME_VALID.
- DIGITS  out  32  frame digits; position i is at bits [4i+3:4i].
- DP  out  8  decimal point per position (1 = lit).
- INVALID  out  8  per position: the segment pattern was not in the decode table.
- FRAME_VALID  out  1  a frame is held in DIGITS/DP/INVALID.
- OVERRUN  out  1  one-cycle pulse: an unacknowledged frame was overwritten.
- SCAN_ERR  out  1  one-cycle pulse: scan order or anode-encoding violation.
- STALLED  out  1  level: no accepted dwell for TIMEOUT_CYCLES.

## Operation
- **Sampling.** SSEG_AN and SSEG_CA are registered every cycle. A stability counter increments while the new sample equals the previous sample, saturates, and clears on any change.
- **Dwell acceptance.** When the counter shows SETTLE_CYCLES equal samples, the dwell is accepted exactly once. No further acceptance occurs until the sample changes and settles again.
- **Anode classification** of an accepted dwell:
  - exactly one bit low: position p = index of that bit;
  - all bits high: idle, ignored (no error, state unchanged);
  - two or more bits low: error.
- **Decode.** Decoding uses CA[6:0] only; CA[7] is ignored by the table. The table is:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Any other value stores digit 0 with invalid=1.
  - dp = ~CA[7].
- **FSM.**
  - WAIT_SYNC: waits for an accepted position 0. On acceptance it stores digit 0 into the working buffer, sets expected=1, and moves to COLLECT. Other positions are silently discarded.
  - COLLECT: an accepted position equal to expected stores that digit, then expected increments. An accepted position 7 completes the frame and returns to WAIT_SYNC.
  - In COLLECT, a wrong position or a multi-low anode pulses SCAN_ERR and discards the working buffer. If the offending position is 0, that position is taken as a new frame start (stay in COLLECT, expected=1); otherwise the FSM goes to WAIT_SYNC.
  - A multi-low anode in WAIT_SYNC also pulses SCAN_ERR.
- **Frame completion.** The working buffer is copied to DIGITS/DP/INVALID and FRAME_VALID is set.
  - If FRAME_VALID was already 1 and FRAME_ACK is not high in the same cycle, OVERRUN pulses.
  - The newest frame always wins.
- **Handshake.** FRAME_ACK=1 while FRAME_VALID=1 clears FRAME_VALID on the next edge.
  - Completion and ACK in the same cycle: the new frame loads, FRAME_VALID stays 1, no OVERRUN.
  - ACK while FRAME_VALID=0 is ignored.
- **Timeout.** A timeout counter clears on every accepted dwell, including idle dwells, and saturates.
  - STALLED=1 once the counter reaches TIMEOUT_CYCLES. On that same cycle the FSM goes to WAIT_SYNC and the working buffer is discarded, with no SCAN_ERR.
  - STALLED clears on the edge of the next accepted dwell.

## Timing
- **Reset.** All outputs are 0: DIGITS=32'h0, DP=8'h00, INVALID=8'h00, FRAME_VALID/OVERRUN/SCAN_ERR/STALLED=0. FSM=WAIT_SYNC, all counters 0, and the sample registers are loaded with 8'hFF.
- **Reset mid-operation.** The partial frame and any held frame are lost. Nothing is output until a fresh position 0 is accepted.
- **Acceptance latency.** Bus values are stable at edges t through t+SETTLE_CYCLES, giving SETTLE_CYCLES equal samples. The acceptance action (store, SCAN_ERR, FRAME_VALID rise) is visible after edge t+SETTLE_CYCLES+1.
- **Glitch rejection.** A bus change lasting fewer than SETTLE_CYCLES cycles is never accepted and does not reset the FSM.
- **Pulse width.** OVERRUN and SCAN_ERR are exactly 1 cycle wide.
- **Output stability.** DIGITS/DP/INVALID change only on a frame-completion edge.

## Test plan
1. Scan positions 0..7 with 16-cycle dwells showing digits 0,1,2,3,4,5,6,7 and dp only on position 3 → FRAME_VALID rises SETTLE_CYCLES+1 cycles after the position-7 dwell starts; DIGITS=32'h76543210, DP=8'h08, INVALID=8'h00.
2. On a stable position-2 dwell, inject 2-cycle glitches of AN=8'hF7 and CA=8'hFF → no SCAN_ERR; the frame completes normally.
3. Scan order 0,1,3 → SCAN_ERR pulses once on the position-3 acceptance and no frame is produced. A following clean 0..7 scan produces a frame.
4. Position 5 shows CA=8'h7F (dp lit, segments blank); other positions show F → DIGITS=32'hFF0FFFFF, INVALID=8'h20, DP=8'h20.
5. Two clean frames with FRAME_ACK=0 → OVERRUN pulses at the second completion and DIGITS holds the second frame. FRAME_ACK for 1 cycle → FRAME_VALID=0 on the next edge.
6. Hold AN=8'hFE with TIMEOUT_CYCLES=64 and SETTLE_CYCLES=4 → STALLED=0. Release the bus to AN=8'hF0 (multi-low) → SCAN_ERR pulse, then STALLED=1 after 64 further cycles. Assert RST_N=0 mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Receive-side monitor for a multiplexed, active-low 8-digit seven-segment bus.
// Rebuilds each scanned frame and presents it to a consumer over valid/ack.
module sseg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  sseg_an_i,
    input  logic [7:0]  sseg_ca_i,
    input  logic        frame_ack_i,
    output logic [31:0] digits_o,
    output logic [7:0]  dp_o,
    output logic [7:0]  invalid_o,
    output logic        frame_valid_o,
    output logic        overrun_o,
    output logic        scan_err_o,
    output logic        stalled_o
);

    localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES + 2);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_ACCEPT = STAB_W'(SETTLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_SAT    = STAB_W'(SETTLE_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_MAX      = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_PRE      = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_COLLECT   = 1'b1
    } state_e;

    logic [7:0]        an_q;
    logic [7:0]        ca_q;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic [TO_W-1:0]   to_q;
    logic [TO_W-1:0]   to_d;
    state_e            state_q;
    state_e            state_d;
    logic [2:0]        exp_q;
    logic [2:0]        exp_d;

    logic [31:0]       wdig_q;
    logic [31:0]       wdig_d;
    logic [7:0]        wdp_q;
    logic [7:0]        wdp_d;
    logic [7:0]        winv_q;
    logic [7:0]        winv_d;

    logic [31:0]       digits_q;
    logic [31:0]       digits_d;
    logic [7:0]        dp_q;
    logic [7:0]        dp_d;
    logic [7:0]        inv_q;
    logic [7:0]        inv_d;
    logic              fv_q;
    logic              fv_d;
    logic              overrun_q;
    logic              overrun_d;
    logic              scan_err_q;
    logic              scan_err_d;

    logic              sample_same;
    logic              accept;
    logic              timeout_hit;
    logic [7:0]        an_low;
    logic              an_idle;
    logic              an_single;
    logic              an_multi;
    logic [2:0]        an_pos;
    logic [3:0]        dec_hex;
    logic              dec_valid;
    logic              wr_en;
    logic              complete;

    // The counter saturates one past the accept threshold so a held dwell fires once.
    assign sample_same = (sseg_an_i == an_q) && (sseg_ca_i == ca_q);
    assign accept      = (stab_q == STAB_ACCEPT);

    always_comb begin
        stab_d = stab_q;
        if (!sample_same) begin
            stab_d = '0;
        end else if (stab_q != STAB_SAT) begin
            stab_d = stab_q + 1'b1;
        end
    end

    always_comb begin
        to_d = to_q;
        if (accept) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
        end
    end

    assign timeout_hit = !accept && (to_q == TO_PRE);

    assign an_low    = ~an_q;
    assign an_idle   = (an_low == 8'h00);
    assign an_single = !an_idle && ((an_low & (an_low - 8'h01)) == 8'h00);
    assign an_multi  = !an_idle && !an_single;

    always_comb begin
        an_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) begin
                an_pos = 3'(i);
            end
        end
    end

    // Segment decode ignores the dp cathode; unknown patterns read back as 0.
    always_comb begin
        dec_hex   = 4'h0;
        dec_valid = 1'b1;
        case (ca_q[6:0])
            7'h40:   dec_hex = 4'h0;
            7'h79:   dec_hex = 4'h1;
            7'h24:   dec_hex = 4'h2;
            7'h30:   dec_hex = 4'h3;
            7'h19:   dec_hex = 4'h4;
            7'h12:   dec_hex = 4'h5;
            7'h02:   dec_hex = 4'h6;
            7'h78:   dec_hex = 4'h7;
            7'h00:   dec_hex = 4'h8;
            7'h10:   dec_hex = 4'h9;
            7'h08:   dec_hex = 4'hA;
            7'h03:   dec_hex = 4'hB;
            7'h46:   dec_hex = 4'hC;
            7'h21:   dec_hex = 4'hD;
            7'h06:   dec_hex = 4'hE;
            7'h0E:   dec_hex = 4'hF;
            default: dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        wr_en      = 1'b0;
        complete   = 1'b0;
        scan_err_d = 1'b0;
        if (accept) begin
            if (an_multi) begin
                scan_err_d = 1'b1;
                state_d    = ST_WAIT_SYNC;
                exp_d      = 3'd0;
            end else if (an_single) begin
                case (state_q)
                    ST_WAIT_SYNC: begin
                        if (an_pos == 3'd0) begin
                            wr_en   = 1'b1;
                            exp_d   = 3'd1;
                            state_d = ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (an_pos == exp_q) begin
                            wr_en = 1'b1;
                            if (an_pos == 3'd7) begin
                                complete = 1'b1;
                                state_d  = ST_WAIT_SYNC;
                                exp_d    = 3'd0;
                            end else begin
                                exp_d = exp_q + 3'd1;
                            end
                        end else begin
                            scan_err_d = 1'b1;
                            if (an_pos == 3'd0) begin
                                // Out-of-order position 0 restarts the frame in place.
                                wr_en = 1'b1;
                                exp_d = 3'd1;
                            end else begin
                                state_d = ST_WAIT_SYNC;
                                exp_d   = 3'd0;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_WAIT_SYNC;
                        exp_d   = 3'd0;
                    end
                endcase
            end
        end else if (timeout_hit) begin
            state_d = ST_WAIT_SYNC;
            exp_d   = 3'd0;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_pos
        logic hit;
        assign hit                = wr_en && (an_pos == 3'(gi));
        assign wdig_d[4*gi +: 4]  = hit ? dec_hex    : wdig_q[4*gi +: 4];
        assign wdp_d[gi]          = hit ? ~ca_q[7]   : wdp_q[gi];
        assign winv_d[gi]         = hit ? ~dec_valid : winv_q[gi];
    end

    // The completing write is folded in through the _d buffer so position 7 lands too.
    always_comb begin
        digits_d  = digits_q;
        dp_d      = dp_q;
        inv_d     = inv_q;
        fv_d      = fv_q;
        overrun_d = 1'b0;
        if (complete) begin
            digits_d  = wdig_d;
            dp_d      = wdp_d;
            inv_d     = winv_d;
            fv_d      = 1'b1;
            overrun_d = fv_q && !frame_ack_i;
        end else if (fv_q && frame_ack_i) begin
            fv_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_q       <= 8'hFF;
            ca_q       <= 8'hFF;
            stab_q     <= '0;
            to_q       <= '0;
            state_q    <= ST_WAIT_SYNC;
            exp_q      <= 3'd0;
            wdig_q     <= 32'h0;
            wdp_q      <= 8'h00;
            winv_q     <= 8'h00;
            digits_q   <= 32'h0;
            dp_q       <= 8'h00;
            inv_q      <= 8'h00;
            fv_q       <= 1'b0;
            overrun_q  <= 1'b0;
            scan_err_q <= 1'b0;
        end else begin
            an_q       <= sseg_an_i;
            ca_q       <= sseg_ca_i;
            stab_q     <= stab_d;
            to_q       <= to_d;
            state_q    <= state_d;
            exp_q      <= exp_d;
            wdig_q     <= wdig_d;
            wdp_q      <= wdp_d;
            winv_q     <= winv_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            inv_q      <= inv_d;
            fv_q       <= fv_d;
            overrun_q  <= overrun_d;
            scan_err_q <= scan_err_d;
        end
    end

    assign digits_o      = digits_q;
    assign dp_o          = dp_q;
    assign invalid_o     = inv_q;
    assign frame_valid_o = fv_q;
    assign overrun_o     = overrun_q;
    assign scan_err_o    = scan_err_q;
    assign stalled_o     = (to_q == TO_MAX);

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: scripted scans with hand-computed frames,
// checked by immediate assertions.
module tb_sseg_scan_decoder;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 64;

    // Cathode bytes per position, position 0 in the low byte.
    localparam logic [63:0] FRAME_A = 64'hF8_82_92_99_30_A4_F9_C0; // 7..0, dp on 3
    localparam logic [63:0] FRAME_B = 64'h8E_86_A1_C6_83_88_90_80; // F..8
    localparam logic [63:0] FRAME_C = 64'h8E_8E_7F_8E_8E_8E_8E_8E; // pos5 blank+dp

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  an = 8'hFF;
    logic [7:0]  ca = 8'hFF;
    logic        ack = 1'b0;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  invalid;
    logic        frame_valid;
    logic        overrun;
    logic        scan_err;
    logic        stalled;

    int n_checks = 0;
    int n_fail   = 0;
    int se_cnt   = 0;
    int ov_cnt   = 0;
    int se_base;
    int ov_base;

    sseg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sseg_an_i    (an),
        .sseg_ca_i    (ca),
        .frame_ack_i  (ack),
        .digits_o     (digits),
        .dp_o         (dp),
        .invalid_o    (invalid),
        .frame_valid_o(frame_valid),
        .overrun_o    (overrun),
        .scan_err_o   (scan_err),
        .stalled_o    (stalled)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (scan_err === 1'b1) se_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            $error("check %s", tag);
        end
    endtask

    task automatic dwell(input logic [7:0] an_v, input logic [7:0] ca_v, input int n);
        an = an_v;
        ca = ca_v;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] an_of(input int p);
        logic [7:0] one;
        one = 8'h01;
        return 8'hFF ^ (one << p);
    endfunction

    // Scans positions 0..7; returns 5 cycles into the position-7 dwell,
    // one edge before its acceptance.
    task automatic scan_frame(input logic [63:0] cav, input bit glitch);
        for (int p = 0; p < 8; p++) begin
            if (p == 7) begin
                dwell(an_of(p), cav[8*p +: 8], 5);
            end else if (glitch && p == 2) begin
                dwell(an_of(p), cav[8*p +: 8], 1);
                dwell(8'hF7,    cav[8*p +: 8], 2);
                dwell(an_of(p), cav[8*p +: 8], 2);
                dwell(an_of(p), 8'hFF,         2);
                dwell(an_of(p), cav[8*p +: 8], 16);
            end else begin
                dwell(an_of(p), cav[8*p +: 8], 16);
            end
        end
    endtask

    task automatic ack_frame(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check(tag, frame_valid, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_digits",   digits,      32'h0);
        check("reset_dp",       dp,          8'h00);
        check("reset_invalid",  invalid,     8'h00);
        check("reset_valid",    frame_valid, 0);
        check("reset_overrun",  overrun,     0);
        check("reset_scan_err", scan_err,    0);
        check("reset_stalled",  stalled,     0);
        rst_n = 1'b1;
        dwell(8'hFF, 8'hFF, 8);

        // Clean frame 7..0 with dp on position 3
        scan_frame(FRAME_A, 1'b0);
        check("t1_valid_early", frame_valid, 0);
        dwell(8'h7F, 8'hF8, 1);
        check("t1_valid",   frame_valid, 1);
        check("t1_digits",  digits,      32'h76543210);
        check("t1_dp",      dp,          8'h08);
        check("t1_invalid", invalid,     8'h00);
        dwell(8'h7F, 8'hF8, 10);
        ack_frame("t1_ack");

        // Short glitches on position 2 before it settles
        se_base = se_cnt;
        scan_frame(FRAME_A, 1'b1);
        dwell(8'h7F, 8'hF8, 1);
        check("t2_valid",  frame_valid, 1);
        check("t2_digits", digits,      32'h76543210);
        check("t2_no_err", se_cnt - se_base, 0);
        dwell(8'h7F, 8'hF8, 10);
        ack_frame("t2_ack");

        // Order 0,1,3 then a clean F..8 frame
        se_base = se_cnt;
        dwell(8'hFE, 8'hC0, 16);
        dwell(8'hFD, 8'hF9, 16);
        dwell(8'hF7, 8'hB0, 5);
        check("t3_err_early", scan_err, 0);
        dwell(8'hF7, 8'hB0, 1);
        check("t3_err_pulse", scan_err, 1);
        dwell(8'hF7, 8'hB0, 1);
        check("t3_err_width", scan_err, 0);
        dwell(8'hF7, 8'hB0, 9);
        check("t3_no_frame", frame_valid, 0);
        check("t3_err_count", se_cnt - se_base, 1);
        scan_frame(FRAME_B, 1'b0);
        check("t3_digits_hold", digits, 32'h76543210);
        dwell(8'h7F, 8'h8E, 1);
        check("t3_valid",  frame_valid, 1);
        check("t3_digits", digits,      32'hFEDCBA98);
        check("t3_dp",     dp,          8'h00);
        dwell(8'h7F, 8'h8E, 10);
        ack_frame("t3_ack");

        // Undecodable pattern with dp on position 5
        scan_frame(FRAME_C, 1'b0);
        dwell(8'h7F, 8'h8E, 1);
        check("t4_digits",  digits,  32'hFF0FFFFF);
        check("t4_invalid", invalid, 8'h20);
        check("t4_dp",      dp,      8'h20);
        dwell(8'h7F, 8'h8E, 10);
        ack_frame("t4_ack");

        // Overrun, simultaneous completion+ack, stray ack
        ov_base = ov_cnt;
        scan_frame(FRAME_A, 1'b0);
        dwell(8'h7F, 8'hF8, 1);
        check("t5_first_valid", frame_valid, 1);
        dwell(8'h7F, 8'hF8, 10);
        check("t5_no_ovr_first", ov_cnt - ov_base, 0);
        scan_frame(FRAME_B, 1'b0);
        check("t5_ovr_early", overrun, 0);
        dwell(8'h7F, 8'h8E, 1);
        check("t5_ovr_pulse",  overrun,     1);
        check("t5_ovr_digits", digits,      32'hFEDCBA98);
        check("t5_ovr_valid",  frame_valid, 1);
        dwell(8'h7F, 8'h8E, 1);
        check("t5_ovr_width",  overrun, 0);
        dwell(8'h7F, 8'h8E, 9);
        check("t5_ovr_count", ov_cnt - ov_base, 1);
        scan_frame(FRAME_A, 1'b0);
        ack = 1'b1;
        dwell(8'h7F, 8'hF8, 1);
        ack = 1'b0;
        check("t5_same_valid",  frame_valid, 1);
        check("t5_same_ovr",    overrun,     0);
        check("t5_same_digits", digits,      32'h76543210);
        dwell(8'h7F, 8'hF8, 10);
        check("t5_same_count", ov_cnt - ov_base, 1);
        ack_frame("t5_ack");
        ack = 1'b1;
        dwell(8'h7F, 8'hF8, 1);
        ack = 1'b0;
        check("t5_stray_ack_valid",  frame_valid, 0);
        check("t5_stray_ack_digits", digits,      32'h76543210);

        // Timeout after a multi-low anode, then recovery and mid-frame reset
        se_base = se_cnt;
        dwell(8'hFE, 8'hC0, 20);
        check("t6_not_stalled", stalled, 0);
        dwell(8'hF0, 8'hC0, 6);
        check("t6_multi_err", scan_err, 1);
        dwell(8'hF0, 8'hC0, 63);
        check("t6_stall_early", stalled, 0);
        dwell(8'hF0, 8'hC0, 1);
        check("t6_stalled",   stalled, 1);
        check("t6_err_count", se_cnt - se_base, 1);
        dwell(8'hFF, 8'hFF, 6);
        check("t6_stall_clear", stalled, 0);

        scan_frame(FRAME_B, 1'b0);
        dwell(8'h7F, 8'h8E, 11);
        check("t6_held_valid", frame_valid, 1);
        dwell(8'hFE, 8'h80, 16);
        dwell(8'hFD, 8'h90, 8);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_digits",   digits,      32'h0);
        check("t6_rst_dp",       dp,          8'h00);
        check("t6_rst_invalid",  invalid,     8'h00);
        check("t6_rst_valid",    frame_valid, 0);
        check("t6_rst_overrun",  overrun,     0);
        check("t6_rst_scan_err", scan_err,    0);
        check("t6_rst_stalled",  stalled,     0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 1; p < 8; p++) begin
            dwell(an_of(p), FRAME_B[8*p +: 8], 16);
        end
        check("t6_post_rst_valid",  frame_valid, 0);
        check("t6_post_rst_digits", digits,      32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
